// File: rtl/arb_mux8_way16_if.sv
// arb_mux8_way16_if
// Bundles the eight source channels and the single merged sink channel of
// the 8-to-1 round-robin merger.
//   in1..in8  : source data, channel k is in(k+1)
//   in_valid  : per-channel offer, bit k for channel k
//   in_ready  : per-channel accept, at most one bit set
//   out       : merged data word
//   out_sel   : index of the channel that supplied out
//   out_valid : out/out_sel hold a word
//   out_ready : sink accepts out
// Modport slave is the merger's view; modport master is the environment's.
interface arb_mux8_way16_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [WIDTH-1:0] in4;
  logic [WIDTH-1:0] in5;
  logic [WIDTH-1:0] in6;
  logic [WIDTH-1:0] in7;
  logic [WIDTH-1:0] in8;
  logic [7:0]       in_valid;
  logic [7:0]       in_ready;
  logic [WIDTH-1:0] out;
  logic [2:0]       out_sel;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in1, in2, in3, in4, in5, in6, in7, in8,
    input  in_valid,
    output in_ready,
    output out, out_sel, out_valid,
    input  out_ready
  );

  modport master (
    output in1, in2, in3, in4, in5, in6, in7, in8,
    output in_valid,
    input  in_ready,
    input  out, out_sel, out_valid,
    output out_ready
  );
endinterface

// File: rtl/arb_mux8_way16.sv
// arb_mux8_way16
// Merges eight valid/ready source channels into one registered output stage
// using a round-robin pointer; the inverse of the 8-way 16-bit demultiplexer.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : arb_mux8_way16_if.slave (sources in, merged sink out)
// in_ready is combinational; out, out_sel and out_valid are registered.
// Only WIDTH = 16 is supported.
module arb_mux8_way16 #(
  parameter int WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  arb_mux8_way16_if.slave       bus
);

  logic [WIDTH-1:0] out_r;
  logic [2:0]       out_sel_r;
  logic             out_valid_r;
  logic [2:0]       ptr_r;

  logic             load_s;
  logic             any_s;
  logic [2:0]       winner_s;
  logic [WIDTH-1:0] data_s;
  logic [7:0]       in_ready_s;

  // The stage can take a new word when it is empty or is being drained.
  assign load_s = !out_valid_r || bus.out_ready;
  assign any_s  = |bus.in_valid;

  // Round-robin search: scan from ptr+7 down to ptr so the channel closest
  // to ptr (in wrap-around order) is the last, and therefore winning, hit.
  always_comb begin
    winner_s = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (bus.in_valid[ptr_r + 3'(i)]) begin
        winner_s = ptr_r + 3'(i);
      end else begin
        winner_s = winner_s;
      end
    end
  end

  // Select the winning channel's data word.
  always_comb begin
    data_s = {WIDTH{1'b0}};
    case (winner_s)
      3'd0:    data_s = bus.in1;
      3'd1:    data_s = bus.in2;
      3'd2:    data_s = bus.in3;
      3'd3:    data_s = bus.in4;
      3'd4:    data_s = bus.in5;
      3'd5:    data_s = bus.in6;
      3'd6:    data_s = bus.in7;
      3'd7:    data_s = bus.in8;
      default: data_s = {WIDTH{1'b0}};
    endcase
  end

  // One-hot grant; suppressed during reset so nothing is accepted then.
  always_comb begin
    in_ready_s = 8'h00;
    if (!reset && load_s && any_s) begin
      in_ready_s = 8'h01 << winner_s;
    end else begin
      in_ready_s = 8'h00;
    end
  end

  // Output stage and round-robin pointer update.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_r       <= {WIDTH{1'b0}};
      out_sel_r   <= 3'd0;
      out_valid_r <= 1'b0;
      ptr_r       <= 3'd0;
    end else if (load_s) begin
      if (any_s) begin
        out_r       <= data_s;
        out_sel_r   <= winner_s;
        out_valid_r <= 1'b1;
        // 3-bit add wraps channel 7 back to 0.
        ptr_r       <= winner_s + 3'd1;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out       = out_r;
  assign bus.out_sel   = out_sel_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_arb_mux8_way16.sv
// tb_arb_mux8_way16
// Self-checking bench for arb_mux8_way16: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_arb_mux8_way16;

  logic        clock;
  logic        reset;
  logic [15:0] din [8];

  int n_cmp;
  int n_mis;

  // Behavioural model state.
  int          m_ptr;
  bit          m_valid;
  logic [15:0] m_out;
  int          m_sel;

  arb_mux8_way16_if #(.WIDTH(16)) bus ();

  arb_mux8_way16 #(.WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.in1 = din[0];
  assign bus.in2 = din[1];
  assign bus.in3 = din[2];
  assign bus.in4 = din[3];
  assign bus.in5 = din[4];
  assign bus.in6 = din[5];
  assign bus.in7 = din[6];
  assign bus.in8 = din[7];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // First channel at or after ptr (wrap-around) that offers a word, else -1.
  function automatic int model_winner(input int ptr, input logic [7:0] v);
    for (int j = 0; j < 8; j++) begin
      if (v[(ptr + j) % 8]) return (ptr + j) % 8;
    end
    return -1;
  endfunction

  // Check one cycle against the model, then advance one clock edge.
  task automatic step();
    int         w;
    bit         ld;
    logic [7:0] exp_rdy;
    #2;
    w  = model_winner(m_ptr, bus.in_valid);
    ld = !m_valid || bus.out_ready;
    exp_rdy = (!reset && ld && w >= 0) ? 8'(1 << w) : 8'h00;
    check("in_ready", {24'h0, bus.in_ready}, {24'h0, exp_rdy});
    check("out_valid", {31'h0, bus.out_valid}, {31'h0, m_valid});
    check("out", {16'h0, bus.out}, {16'h0, m_out});
    check("out_sel", {29'h0, bus.out_sel}, m_sel);
    @(posedge clock);
    if (reset) begin
      m_ptr = 0; m_valid = 1'b0; m_out = 16'h0000; m_sel = 0;
    end else if (ld) begin
      if (w >= 0) begin
        m_out = din[w]; m_sel = w; m_valid = 1'b1; m_ptr = (w + 1) % 8;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    m_ptr = 0; m_valid = 1'b0; m_out = 16'h0000; m_sel = 0;
    for (int k = 0; k < 8; k++) din[k] = 16'h0000;
    reset = 1'b1;
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;

    // Reset held two cycles with every channel offering.
    step();
    step();
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rst_out", {16'h0, bus.out}, 32'h0);

    // Fairness and wrap from ptr 0: sel 0..7,0,1 back to back.
    reset = 1'b0;
    for (int k = 0; k < 8; k++) din[k] = 16'h0010 + 16'(k);
    bus.in_valid = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      step();
      check("rr_sel", {29'h0, bus.out_sel}, i % 8);
      check("rr_out", {16'h0, bus.out}, 32'h0010 + (i % 8));
      check("rr_valid", {31'h0, bus.out_valid}, 32'h1);
    end

    // Single channel after a fresh reset.
    reset = 1'b1; bus.in_valid = 8'h00;
    step();
    reset = 1'b0;
    din[3] = 16'hBEEF; bus.in_valid = 8'h08; bus.out_ready = 1'b1;
    #2;
    check("single_rdy", {24'h0, bus.in_ready}, 32'h08);
    step();
    check("single_out", {16'h0, bus.out}, 32'hBEEF);
    check("single_sel", {29'h0, bus.out_sel}, 32'd3);

    // Backpressure: hold 16'h1234 from channel 1 for five stalled cycles.
    din[1] = 16'h1234; bus.in_valid = 8'h02;
    step();
    bus.in_valid = 8'hFF; bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_out", {16'h0, bus.out}, 32'h1234);
    end
    bus.out_ready = 1'b1;
    #2;
    check("bp_next", {24'h0, bus.in_ready}, 32'h04);
    step();

    // Skip: reach ptr 6 via channel 5, then alternate 0 and 2.
    bus.in_valid = 8'h20;
    step();
    bus.in_valid = 8'h05;
    step();
    check("skip_a", {29'h0, bus.out_sel}, 32'd0);
    step();
    check("skip_b", {29'h0, bus.out_sel}, 32'd2);
    step();
    check("skip_c", {29'h0, bus.out_sel}, 32'd0);

    // Reset mid-stream discards the held word and restores priority.
    bus.in_valid = 8'h80;
    step();
    reset = 1'b1;
    step();
    check("mid_rst_valid", {31'h0, bus.out_valid}, 32'h0);
    reset = 1'b0; bus.in_valid = 8'h81;
    #2;
    check("mid_rst_rdy", {24'h0, bus.in_ready}, 32'h01);
    step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 8; k++) din[k] = 16'($urandom);
      bus.in_valid  = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      reset         = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/arb_mux8_way16.md
ARB_MUX8_WAY16 -- requirements
Module: arb_mux8_way16

Interface
REQ-001 Parameter: WIDTH, 16, data width of every channel; WIDTH=16 is the only supported value.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in1..in8  input  16 each  source channel data; channel k (k=0..7) is in(k+1).
REQ-005 in_valid  input  8  bit k set = channel k offers a word this cycle.
REQ-006 in_ready  output  8  bit k set = channel k word accepted this cycle; combinational, at most one bit set.
REQ-007 out  output  16  registered merged data.
REQ-008 out_sel  output  3  registered index of the channel that supplied out; encoding matches the sel of the 8-way demultiplexer (0 = in1, 7 = in8).
REQ-009 out_valid  output  1  registered; out/out_sel hold a word.
REQ-010 out_ready  input  1  sink accepts out this cycle.

Function
REQ-011 The block shall merge 8 valid/ready source channels into one output stage, one word per transfer, as the inverse of the 8-way 16-bit demultiplexer.
REQ-012 Transfer rules: a source transfer occurs when in_valid[k] and in_ready[k] are both 1; a sink transfer occurs when out_valid and out_ready are both 1.
REQ-013 Load enable: load = (!out_valid || out_ready); in_ready shall be all-zero when load = 0.
REQ-014 Arbitration: round-robin pointer ptr[2:0]; the winner is the first k with in_valid[k]=1, searching ptr, ptr+1, ..., ptr+7 mod 8.
REQ-015 When load=1 and any in_valid bit is set, in_ready[winner]=1 in the same cycle; on the next edge out<=in(winner+1), out_sel<=winner, out_valid<=1, ptr<=winner+1 mod 8 (winner 7 wraps ptr to 0).
REQ-016 When load=1 and in_valid=0: out_valid<=0; out, out_sel and ptr hold.
REQ-017 When out_valid=1 and out_ready=0: out, out_sel, out_valid and ptr shall hold; no source transfer occurs.
REQ-018 Simultaneous sink transfer and new grant in one cycle shall be supported, giving sustained throughput of 1 word/cycle with zero bubbles.
REQ-019 Latency: 1 cycle from source transfer to out_valid.
REQ-020 The ptr shall not advance on cycles with no grant; a channel that deasserts in_valid before being granted is skipped without error.
REQ-021 in_ready shall not depend on out_ready when out_valid=0.

Reset
REQ-022 When reset=1 at a rising edge: out_valid=0, out=16'h0000, out_sel=0, ptr=0.
REQ-023 While reset=1, in_ready shall be 8'h00 and no word is captured; a word held at reset assertion is discarded.
REQ-024 Operation resumes on the first edge with reset=0, with channel 0 (in1) having top priority.

Verification
REQ-025 Reset: assert reset for 2 cycles with in_valid=8'hFF -> in_ready=8'h00 throughout, out_valid=0, out=0, out_sel=0.
REQ-026 Single channel: in_valid=8'h08, in4=16'hBEEF, out_ready=1 -> in_ready=8'h08; next cycle out=16'hBEEF, out_sel=3, out_valid=1; ptr=4.
REQ-027 Fairness/wrap: in_valid=8'hFF held, out_ready=1, in(k+1)=16'h0010+k -> out_sel sequence 0,1,...,7,0,1 on consecutive cycles with out matching; no idle cycles.
REQ-028 Backpressure: out_valid=1, out=16'h1234, out_ready=0 for 5 cycles with in_valid=8'hFF -> out, out_sel stable, in_ready=8'h00; on out_ready=1, the next grant goes to the channel after the held out_sel.
REQ-029 Skip: ptr=6, in_valid=8'h05 -> grant channel 0, then channel 2, then channel 0 again.
REQ-030 Reset mid-stream: reset=1 for 1 cycle while out_valid=1 and in_valid=8'h80 -> out_valid=0, ptr=0; after release with in_valid=8'h81, channel 0 is granted first.
